imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Parametrised instruction memory: word storage, streaming program loader and registered fetch port.
//  Sits between the boot/debug loader and the core fetch stage.
//  After reset it clears itself to FILL_WORD one word per cycle, then serves fetches.
//  Loads are accepted over a valid/ready stream at any word base address.
// PARAMETERS
//  DATA_WIDTH  32             word width in bits; power of two, >= 8
//  DEPTH       1024           number of words; power of two
//  ADDR_WIDTH  32             fetch byte-address width
//  FILL_WORD   32'hFFFF_FFFF  value written by CLEAR (DATA_WIDTH wide)
//  localparam  IDX_W = $clog2(DEPTH), LSB_W = $clog2(DATA_WIDTH/8)
// PORTS
//  clk          in   1           single clock; all logic on posedge
//  rstn         in   1           synchronous, active-low reset
//  clr          in   1           request re-clear of the whole array (sampled in IDLE)
//  ld_start     in   1           start a load (sampled in IDLE)
//  ld_base      in   IDX_W       first word index of the load, sampled with ld_start
//  ld_valid     in   1           load beat valid
//  ld_data      in   DATA_WIDTH  load beat data
//  ld_last      in   1           final beat of the load, qualified by ld_valid
//  ld_ready     out  1           loader accepts a beat (=1 only in LOAD)
//  ld_done      out  1           one-cycle pulse after the last-beat handshake
//  ld_overflow  out  1           sticky: load ran past DEPTH-1; cleared by the next accepted ld_start
//  busy         out  1           state != IDLE
//  rd_en        in   1           fetch request
//  rd_addr      in   ADDR_WIDTH  fetch byte address
//  rd_data      out  DATA_WIDTH  fetched word, 1-cycle latency
//  rd_valid     out  1           rd_data valid
//  rd_err       out  1           with rd_valid: misaligned or out-of-range address
//  parity_err   out  1           with rd_valid: stored parity mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rstn=0 at posedge), from any state including mid-LOAD or mid-CLEAR:
//   - state=CLEAR, clear_ptr=0; rd_data=0; rd_valid, rd_err, parity_err, ld_done, ld_overflow=0.
//   - ld_ready=0, busy=1. Array contents are not reset directly.
//  CLEAR: writes FILL_WORD to word clear_ptr each cycle. After writing DEPTH-1, goes to IDLE.
//   - First fetch is accepted DEPTH cycles after reset release.
//  IDLE:
//   - clr=1 -> CLEAR with clear_ptr=0. clr has priority over a same-cycle ld_start.
//   - ld_start=1 -> LOAD with ptr=ld_base; clears ld_overflow.
//   - ld_start and clr are ignored outside IDLE.
//  LOAD: ld_ready=1. Handshake = ld_valid & ld_ready.
//   - Each handshake writes ld_data to mem[ptr] and increments ptr.
//   - A handshake at ptr=DEPTH-1 without ld_last sets ld_overflow.
//     Later beats are accepted (drained) but discarded; no wrap to index 0.
//   - A handshake with ld_last -> IDLE next cycle. ld_done=1 for exactly that cycle.
//   - No timeout; the load stays in LOAD until ld_last.
//  Fetch: accepted only when state==IDLE and rd_en=1. Next cycle:
//   - rd_valid=1; index = rd_addr >> LSB_W.
//   - rd_err=1 if rd_addr[LSB_W-1:0]!=0 (data still from the truncated index),
//     or if index >= DEPTH (rd_data=0).
//   - rd_en outside IDLE: rd_valid=0 next cycle; rd_data holds its last value.
//   - Without a request, rd_valid=0 and rd_data holds.
//  Simultaneous events:
//   - The last load beat and a fetch of the same index cannot collide (fetch is blocked in LOAD).
//   - A fetch issued in the IDLE cycle that follows ld_done returns the new data.
// CONFIGURATION
//  IMEM_PARITY_EN defined:
//   - Each word stores an extra even-parity bit, computed on every write (CLEAR and LOAD).
//   - On fetch, parity_err=1 with rd_valid if the recomputed parity != stored parity.
//  IMEM_PARITY_EN undefined:
//   - No parity storage; parity_err tied 0. Port list is unchanged.
// STRUCTURE
//  Package imem_pkg:
//   - typedef enum {CLEAR, IDLE, LOAD} imem_state_t
//   - function clog2 helper
//   - parity function
//  Sub-module imem_array:
//   - DEPTH x (DATA_WIDTH + parity) storage.
//   - One synchronous write port and one registered read port.
//   - Read data is muxed to 0 on the out-of-range flag in the parent.
//  FSM, pointers and flags live in imem_loader.
// TESTING
//  Reset with DEPTH=16:
//   - busy=1 for 16 cycles, then 0.
//   - Every index reads back 32'hFFFF_FFFF, rd_err=0.
//  Load:
//   - ld_base=4, beats 0xA0..0xA3, last on 0xA3.
//   - ld_done pulses once. Fetches at byte 0x10..0x1C return A0..A3. Byte 0x0C still returns FFFF_FFFF.
//  Overflow:
//   - ld_base=14, 4 beats, no last until the 4th.
//   - ld_overflow=1. idx14/15 are written; idx0/1 unchanged; ld_ready stays 1 throughout.
//  Address faults:
//   - rd_addr=0x11 -> rd_err=1, data=mem[4].
//   - rd_addr=0x40 -> rd_err=1, rd_data=0.
//  Contention:
//   - clr and ld_start in the same IDLE cycle -> CLEAR entered, ld_ready stays 0.
//   - rstn=0 mid-LOAD -> CLEAR; ld_done is never pulsed.
//  Parity (IMEM_PARITY_EN):
//   - Force the stored parity bit of idx5 -> fetch 0x14 gives parity_err=1.
//   - Without the macro, parity_err=0 for every fetch.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory loader.
//   imem_state_t : controller states (CLEAR, IDLE, LOAD)
//   clog2        : ceiling log2, usable in constant expressions
//   even_parity  : even-parity bit of a zero-extended word (XOR of all bits)
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } imem_state_t;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAX_W = 256;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Zero-extension does not change the XOR, so one helper serves any width.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word storage for imem_loader: one synchronous write port and one
// registered read port. The storage itself is never reset; only the read
// register is, so the fetch output starts at zero.
//   clk, rstn    : clock, synchronous active-low reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata updates the cycle after re=1, else holds
module imem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with self-clear, streaming program loader and a
// registered fetch port. After reset the array is filled with FILL_WORD one
// word per cycle (CLEAR), then fetches are served in IDLE. A load streams
// words from ld_base upward; beats past the last index are drained and
// dropped, flagging ld_overflow.
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per
// word and report mismatches on parity_err (tied 0 otherwise).
// Ports:
//   clk, rstn        : clock, synchronous active-low reset
//   clr, ld_start    : re-clear / start load requests, honoured only in IDLE
//   ld_base          : first word index of a load
//   ld_valid/ld_data/ld_last/ld_ready : load beat stream
//   ld_done          : one-cycle pulse after the last beat is accepted
//   ld_overflow      : sticky, load ran past the last index
//   busy             : controller not in IDLE
//   rd_en/rd_addr    : fetch request (byte address)
//   rd_data/rd_valid/rd_err/parity_err : fetch response, one cycle later
module imem_loader
  import imem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 32'hFFFF_FFFF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clr,
  input  logic                        ld_start,
  input  logic [clog2(DEPTH)-1:0]     ld_base,
  input  logic                        ld_valid,
  input  logic [DATA_WIDTH-1:0]       ld_data,
  input  logic                        ld_last,
  output logic                        ld_ready,
  output logic                        ld_done,
  output logic                        ld_overflow,
  output logic                        busy,
  input  logic                        rd_en,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic                        rd_err,
  output logic                        parity_err
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int LSB_W = clog2(DATA_WIDTH / 8);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << LSB_W) - 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_IDX  = ADDR_WIDTH'(DEPTH - 1);

  imem_state_t       state, state_next;
  logic [IDX_W-1:0]  clear_ptr, ptr;
  logic              hs, fetch, misaligned, oor, oor_q;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [MEM_W-1:0]  wdata, fill_mem, ld_mem, arr_q;

  assign hs       = (state == LOAD) & ld_valid;
  assign ld_ready = (state == LOAD);
  assign busy     = (state != IDLE);

  assign fetch      = (state == IDLE) & rd_en;
  assign idx_full   = rd_addr >> LSB_W;
  assign misaligned = |(rd_addr & LSB_MASK);
  assign oor        = (idx_full > MAX_IDX);

`ifdef IMEM_PARITY_EN
  assign fill_mem = {even_parity(PAR_MAX_W'(FILL_WORD)), FILL_WORD};
  assign ld_mem   = {even_parity(PAR_MAX_W'(ld_data)), ld_data};
`else
  assign fill_mem = FILL_WORD;
  assign ld_mem   = ld_data;
`endif

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR: begin
        if (clear_ptr == LAST_IDX) state_next = IDLE;
        else                       state_next = CLEAR;
      end
      IDLE: begin
        if (clr)           state_next = CLEAR;
        else if (ld_start) state_next = LOAD;
        else               state_next = IDLE;
      end
      LOAD: begin
        if (hs && ld_last) state_next = LOAD == LOAD ? IDLE : IDLE;
        else               state_next = LOAD;
      end
      default: state_next = CLEAR;
    endcase
  end

  // Write-port mux: clear fill or load beat; drained overflow beats never write.
  always_comb begin
    we    = 1'b0;
    waddr = clear_ptr;
    wdata = fill_mem;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clear_ptr;
        wdata = fill_mem;
      end
      LOAD: begin
        we    = hs & ~ld_overflow;
        waddr = ptr;
        wdata = ld_mem;
      end
      default: begin
        we = 1'b0;
      end
    endcase
  end

  // State register, pointers and load flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= CLEAR;
      clear_ptr   <= '0;
      ptr         <= '0;
      ld_done     <= 1'b0;
      ld_overflow <= 1'b0;
    end else begin
      state   <= state_next;
      ld_done <= hs & ld_last;
      case (state)
        CLEAR: clear_ptr <= clear_ptr + IDX_W'(1);  // wraps back to 0 on exit
        IDLE: begin
          if (clr) begin
            clear_ptr <= '0;
          end else if (ld_start) begin
            ptr         <= ld_base;
            ld_overflow <= 1'b0;
          end
        end
        LOAD: begin
          // ld_overflow doubles as the drain flag: it was cleared at ld_start.
          if (hs && !ld_overflow) begin
            if (ptr == LAST_IDX && !ld_last) ld_overflow <= 1'b1;
            else                             ptr <= ptr + IDX_W'(1);
          end
        end
        default: clear_ptr <= '0;
      endcase
    end
  end

  // Fetch response flags; oor_q holds so rd_data keeps masking until the next fetch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      rd_valid <= fetch;
      rd_err   <= fetch & (misaligned | oor);
      if (fetch) oor_q <= oor;
    end
  end

  imem_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (fetch & ~oor),
    .raddr (idx_full[IDX_W-1:0]),
    .rdata (arr_q)
  );

  assign rd_data = oor_q ? '0 : arr_q[DATA_WIDTH-1:0];

`ifdef IMEM_PARITY_EN
  assign parity_err = rd_valid & ~oor_q &
                      (even_parity(PAR_MAX_W'(arr_q[DATA_WIDTH-1:0])) != arr_q[DATA_WIDTH]);
`else
  assign parity_err = 1'b0;
`endif

endmodule
